// File: rtl/serial_compare_ctrl.sv
// Bit-serial magnitude compare sequencer driving a shared 1-bit equality comparator, MSB first.
// Optional EARLY_EXIT_EN: finish on the first mismatching bit instead of scanning all WIDTH bits.
module serial_compare_ctrl #(
    parameter  int WIDTH = 8,
    localparam int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             cmp_x_o,
    output logic             cmp_y_o,
    input  logic             cmp_z_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             eq_o,
    output logic             gt_o,
    output logic             lt_o,
    output logic [CW-1:0]    bit_idx_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [CW-1:0]    bit_idx_q;
    logic             mism_q;
    logic             gt_int_q;
    logic             busy_q;
    logic             done_q;
    logic             eq_q;
    logic             gt_q;
    logic             lt_q;

    logic             bit_x;
    logic             bit_y;
    logic             mism_d;
    logic             gt_int_d;
    logic             finish;

    always_comb begin
        bit_x    = a_q[bit_idx_q];
        bit_y    = b_q[bit_idx_q];
        mism_d   = mism_q | ~cmp_z_i;
        // Only the most significant differing bit decides the ordering.
        gt_int_d = (!mism_q && !cmp_z_i) ? bit_x : gt_int_q;
`ifdef EARLY_EXIT_EN
        finish   = (bit_idx_q == '0) || mism_d;
`else
        finish   = (bit_idx_q == '0);
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            bit_idx_q <= '0;
            mism_q    <= 1'b0;
            gt_int_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            eq_q      <= 1'b0;
            gt_q      <= 1'b0;
            lt_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        state_q   <= S_RUN;
                        a_q       <= a_i;
                        b_q       <= b_i;
                        bit_idx_q <= CW'(WIDTH - 1);
                        mism_q    <= 1'b0;
                        gt_int_q  <= 1'b0;
                        eq_q      <= 1'b0;
                        gt_q      <= 1'b0;
                        lt_q      <= 1'b0;
                        busy_q    <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    mism_q   <= mism_d;
                    gt_int_q <= gt_int_d;
                    if (finish) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        eq_q    <= ~mism_d;
                        gt_q    <= mism_d & gt_int_d;
                        lt_q    <= mism_d & ~gt_int_d;
                    end else begin
                        bit_idx_q <= bit_idx_q - CW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmp_x_o   = (state_q == S_RUN) & bit_x;
    assign cmp_y_o   = (state_q == S_RUN) & bit_y;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign eq_o      = eq_q;
    assign gt_o      = gt_q;
    assign lt_o      = lt_q;
    assign bit_idx_o = bit_idx_q;

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Scoreboard bench for serial_compare_ctrl (WIDTH=8) with a behavioural equality comparator.
module tb_serial_compare_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cmp_x, cmp_y, cmp_z;
    logic       busy, done, eq, gt, lt;
    logic [2:0] bit_idx;

    serial_compare_ctrl #(.WIDTH(8)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .a_i(a), .b_i(b),
        .cmp_x_o(cmp_x), .cmp_y_o(cmp_y), .cmp_z_i(cmp_z),
        .busy_o(busy), .done_o(done), .eq_o(eq), .gt_o(gt), .lt_o(lt),
        .bit_idx_o(bit_idx)
    );

    assign cmp_z = (cmp_x == cmp_y);

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef EARLY_EXIT_EN
    localparam int L3 = 2;
    localparam int L4 = 7;
`else
    localparam int L3 = 9;
    localparam int L4 = 9;
`endif

    localparam logic [2:0] R_EQ = 3'b100;
    localparam logic [2:0] R_GT = 3'b010;
    localparam logic [2:0] R_LT = 3'b001;

    typedef struct {
        logic [2:0] res;
        int         t0;
        int         lat;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                check({e.name, " eq/gt/lt"}, 32'({eq, gt, lt}), 32'(e.res));
                check({e.name, " latency"}, 32'(cyc - e.t0 + 1), 32'(e.lat));
                check({e.name, " onehot"}, 32'($countones({eq, gt, lt})), 32'd1);
            end
        end
    end

    task automatic issue(input logic [7:0] av, input logic [7:0] bv, input logic [2:0] res,
                         input int lat, input string nm);
        @(negedge clk);
        a = av;
        b = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back('{res, cyc, lat, nm});
        start = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string nm);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL %s timeout: got %0d pending expected 0", nm, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat;
        int d0;
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;

        // 1: reset
        repeat (3) @(negedge clk);
        check("reset outputs", 32'({busy, done, eq, gt, lt, cmp_x, cmp_y, bit_idx}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post-reset outputs", 32'({busy, done, eq, gt, lt, cmp_x, cmp_y, bit_idx}), 32'd0);
        repeat (20) @(negedge clk);
        check("idle busy", 32'(busy), 32'd0);

        // 2: equal operands, serial presentation
        pat = 8'hA5;
        @(negedge clk);
        a = 8'hA5;
        b = 8'hA5;
        start = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back('{R_EQ, cyc, 9, "t2"});
        start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check($sformatf("t2 cmp_x c%0d", k), 32'(cmp_x), 32'(pat[8-k]));
            check($sformatf("t2 cmp_y c%0d", k), 32'(cmp_y), 32'(pat[8-k]));
            check($sformatf("t2 bit_idx c%0d", k), 32'(bit_idx), 32'(8 - k));
            check($sformatf("t2 busy c%0d", k), 32'(busy), 32'd1);
        end
        wait_drain(20, "t2");
        @(negedge clk);
        check("t2 eq held", 32'({eq, gt, lt}), 32'(R_EQ));
        check("t2 idle cmp/busy", 32'({cmp_x, cmp_y, busy, done}), 32'd0);

        // 3: a > b, mismatch at MSB
        issue(8'h80, 8'h7F, R_GT, L3, "t3");
        wait_drain(20, "t3");

        // 4: a < b, first mismatch at bit 2
        issue(8'h03, 8'h05, R_LT, L4, "t4");
        wait_drain(20, "t4");

        // 5: starts during RUN ignored; start in DONE restarts at once
        issue(8'h5A, 8'h5A, R_EQ, 9, "t5a");
        repeat (2) @(negedge clk);
        @(negedge clk);
        start = 1'b1; a = 8'hFF; b = 8'h00;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("t5 done in cycle 9", 32'(done), 32'd1);
        a = 8'hC3; b = 8'hC3; start = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back('{R_EQ, cyc, 9, "t5b"});
        start = 1'b0;
        @(negedge clk);
        check("t5 restart busy", 32'(busy), 32'd1);
        wait_drain(20, "t5b");

        // 6: reset mid-RUN aborts without done
        issue(8'h0F, 8'h0F, R_EQ, 9, "t6a");
        repeat (3) @(negedge clk);
        @(negedge clk);
        check("t6 busy before rst", 32'(busy), 32'd1);
        rst = 1'b1;
        sb.delete();
        #1;
        check("t6 abort outputs", 32'({busy, done, eq, gt, lt, cmp_x, cmp_y}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        check("t6 no result after abort", 32'({busy, eq, gt, lt}), 32'd0);
        issue(8'h01, 8'h00, R_GT, 9, "t6b");
        wait_drain(20, "t6b");

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
